// File: rtl/generator_obstacole.sv
// N-lane obstacle generator: moves NUM_OBS obstacles right-to-left at a fixed pitch, respawns gaps and scores passes.
// Define OBST_GOL_ALEATOR_EN to take respawn gap heights from a 16-bit LFSR instead of the mid-range constant.
module generator_obstacole #(
   parameter int NUM_OBS         = 3,
   parameter int LUNGIME_ECRAN   = 1920,
   parameter int LATIME_OBSTACOL = 50,
   parameter int SPATIU_OBS      = 660,
   parameter int X_JUCATOR       = 400,
   parameter int GOL_MIN         = 200,
   parameter int GOL_BITI        = 9,
   parameter int W               = 12
) (
   input  logic                 clk_148Mhz,
   input  logic                 reset,
   input  logic                 tick_obs,
   input  logic                 start,
   input  logic                 pauza,
   input  logic                 coliziune,
   input  logic [5:0]           viteza,
   output logic [NUM_OBS*W-1:0] x_obs,
   output logic [NUM_OBS*W-1:0] y_gol,
   output logic [NUM_OBS-1:0]   activ,
   output logic [15:0]          scor,
   output logic                 scor_puls,
   output logic [1:0]           stare
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUZA = 2'd2,
      OPRIT = 2'd3
   } stare_t;

   localparam logic [W-1:0] PERIOADA = W'(NUM_OBS * SPATIU_OBS);
   localparam logic [W-1:0] X_JUC    = W'(X_JUCATOR);
   localparam logic [W-1:0] GOL_MID  = W'(GOL_MIN + 2**(GOL_BITI-1));

   if (NUM_OBS < 1 || NUM_OBS > 8 ||
       NUM_OBS * SPATIU_OBS < LUNGIME_ECRAN + LATIME_OBSTACOL) begin : g_param_invalid
      $error("generator_obstacole: NUM_OBS or SPATIU_OBS out of range");
   end

   stare_t       stare_q, stare_d;
   logic [W-1:0] x_q [NUM_OBS];
   logic [W-1:0] x_d [NUM_OBS];
   logic [W-1:0] y_q [NUM_OBS];
   logic [W-1:0] y_d [NUM_OBS];
   logic [15:0]  scor_q, scor_d;
   logic         puls_q, puls_d;

   function automatic logic [W-1:0] pozitie_init(input int i);
      return W'(LUNGIME_ECRAN + i * SPATIU_OBS);
   endfunction

`ifdef OBST_GOL_ALEATOR_EN
   logic [15:0] lfsr_q;

   // Fibonacci taps 16,14,13,11: maximal length, so a non-zero seed never reaches 0.
   always_ff @(posedge clk_148Mhz) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   function automatic logic [W-1:0] gol_nou(input logic [GOL_BITI-1:0] r, input int k);
      logic [2*GOL_BITI-1:0] dublu;
      dublu = {r, r} << (k % GOL_BITI);
      return W'(GOL_MIN) + W'(dublu[2*GOL_BITI-1 -: GOL_BITI]);
   endfunction
`endif

   always_comb begin
      logic         mutare;
      logic [W-1:0] viteza_w;
      logic [16:0]  suma;
      int           nr_scor;
`ifdef OBST_GOL_ALEATOR_EN
      int           rang;
      rang = 0;
`endif
      // NOTE: combinational next-state uses blocking '=' with every output defaulted first, so no latches are inferred.
      stare_d  = stare_q;
      x_d      = x_q;
      y_d      = y_q;
      scor_d   = scor_q;
      puls_d   = 1'b0;
      mutare   = 1'b0;
      viteza_w = W'(viteza);
      suma     = '0;
      nr_scor  = 0;

      // State is decided before motion: a tick that coincides with leaving RUN is dropped.
      case (stare_q)
         IDLE, OPRIT: begin
            if (!coliziune && start) begin
               for (int i = 0; i < NUM_OBS; i++) begin
                  x_d[i] = pozitie_init(i);
                  y_d[i] = GOL_MID;
               end
               scor_d  = '0;
               stare_d = RUN;
            end
         end
         RUN: begin
            if (coliziune)  stare_d = OPRIT;
            else if (pauza) stare_d = PAUZA;
            else            mutare  = tick_obs && (viteza != 6'd0);
         end
         PAUZA: begin
            if (coliziune)   stare_d = OPRIT;
            else if (!pauza) stare_d = RUN;
         end
         default: stare_d = IDLE;
      endcase

      if (mutare) begin
         for (int i = 0; i < NUM_OBS; i++) begin
            if (x_q[i] >= viteza_w) begin
               x_d[i] = x_q[i] - viteza_w;
               if (x_q[i] >= X_JUC && x_d[i] < X_JUC) nr_scor++;
            end else begin
               // Adding the full ring length keeps the pitch exact and cannot underflow.
               x_d[i] = x_q[i] + PERIOADA - viteza_w;
`ifdef OBST_GOL_ALEATOR_EN
               y_d[i] = gol_nou(lfsr_q[GOL_BITI-1:0], rang);
               rang++;
`else
               y_d[i] = GOL_MID;
`endif
            end
         end
      end

      if (nr_scor != 0) begin
         puls_d = 1'b1;
         suma   = {1'b0, scor_q} + 17'(nr_scor);
         scor_d = suma[16] ? 16'hFFFF : suma[15:0];
      end
   end

   // NOTE: sequential state uses non-blocking '<='; the position/gap arrays are a few registers, not a RAM, so resetting them is fine.
   always_ff @(posedge clk_148Mhz) begin
      if (reset) begin
         stare_q <= IDLE;
         for (int i = 0; i < NUM_OBS; i++) begin
            x_q[i] <= pozitie_init(i);
            y_q[i] <= GOL_MID;
         end
         scor_q <= '0;
         puls_q <= 1'b0;
      end else begin
         stare_q <= stare_d;
         x_q     <= x_d;
         y_q     <= y_d;
         scor_q  <= scor_d;
         puls_q  <= puls_d;
      end
   end

   always_comb begin
      x_obs = '0;
      y_gol = '0;
      activ = '0;
      for (int i = 0; i < NUM_OBS; i++) begin
         x_obs[i*W +: W] = x_q[i];
         y_gol[i*W +: W] = y_q[i];
         activ[i]        = (x_q[i] < W'(LUNGIME_ECRAN));
      end
   end

   assign scor      = scor_q;
   assign scor_puls = puls_q;
   assign stare     = stare_q;

endmodule

// File: tb/tb_generator_obstacole.sv
// Directed bench for generator_obstacole with default parameters; expected values are hand-computed.
module tb_generator_obstacole;
   localparam int NUM_OBS = 3;
   localparam int W       = 12;
   localparam int NLOG    = 80;

   logic                 clk_148Mhz = 1'b0;
   logic                 reset      = 1'b1;
   logic                 tick_obs   = 1'b0;
   logic                 start      = 1'b0;
   logic                 pauza      = 1'b0;
   logic                 coliziune  = 1'b0;
   logic [5:0]           viteza     = 6'd0;
   logic [NUM_OBS*W-1:0] x_obs;
   logic [NUM_OBS*W-1:0] y_gol;
   logic [NUM_OBS-1:0]   activ;
   logic [15:0]          scor;
   logic                 scor_puls;
   logic [1:0]           stare;

   int errors = 0;
   int checks = 0;
   logic [90:0] log_a [NLOG];
   logic [90:0] log_b [NLOG];

   generator_obstacole dut (
      .clk_148Mhz (clk_148Mhz),
      .reset      (reset),
      .tick_obs   (tick_obs),
      .start      (start),
      .pauza      (pauza),
      .coliziune  (coliziune),
      .viteza     (viteza),
      .x_obs      (x_obs),
      .y_gol      (y_gol),
      .activ      (activ),
      .scor       (scor),
      .scor_puls  (scor_puls),
      .stare      (stare)
   );

   always #5 clk_148Mhz = ~clk_148Mhz;

   function automatic int xo(input int i);
      return int'(x_obs[i*W +: W]);
   endfunction

   function automatic int yo(input int i);
      return int'(y_gol[i*W +: W]);
   endfunction

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic do_tick();
      tick_obs = 1'b1;
      @(negedge clk_148Mhz);
      tick_obs = 1'b0;
   endtask

   task automatic test_reset();
      int exp_x [NUM_OBS];
      exp_x = '{1920, 2580, 3240};
      reset = 1'b1;
      repeat (2) @(negedge clk_148Mhz);
      checks++; if (stare !== 2'd0) begin errors++; $display("FAIL reset_stare: got %0d want 0", stare); end
      checks++; if (scor !== 16'd0 || scor_puls !== 1'b0) begin errors++; $display("FAIL reset_scor: got %0d/%0b want 0/0", scor, scor_puls); end
      checks++; if (activ !== 3'b000) begin errors++; $display("FAIL reset_activ: got %b want 000", activ); end
      for (int i = 0; i < NUM_OBS; i++) begin
         checks++; if (xo(i) != exp_x[i]) begin errors++; $display("FAIL reset_x%0d: got %0d want %0d", i, xo(i), exp_x[i]); end
         checks++; if (yo(i) != 456) begin errors++; $display("FAIL reset_y%0d: got %0d want 456", i, yo(i)); end
      end
      reset = 1'b0;
      @(negedge clk_148Mhz);
      // start together with a tick in IDLE: reload only, no motion.
      start = 1'b1; tick_obs = 1'b1; viteza = 6'd30;
      @(negedge clk_148Mhz);
      start = 1'b0; tick_obs = 1'b0;
      checks++; if (stare !== 2'd1) begin errors++; $display("FAIL start_stare: got %0d want 1", stare); end
      for (int i = 0; i < NUM_OBS; i++) begin
         checks++; if (xo(i) != exp_x[i]) begin errors++; $display("FAIL start_x%0d: got %0d want %0d", i, xo(i), exp_x[i]); end
      end
      checks++; if (activ !== 3'b000 || scor !== 16'd0) begin errors++; $display("FAIL start_activ_scor: got %b/%0d want 000/0", activ, scor); end
   endtask

   task automatic test_motion();
      repeat (12) do_tick();
      checks++; if (xo(0) != 1560) begin errors++; $display("FAIL motion_x0: got %0d want 1560", xo(0)); end
      checks++; if (activ !== 3'b001) begin errors++; $display("FAIL motion_activ: got %b want 001", activ); end
      repeat (38) do_tick();
      checks++; if (xo(0) != 420 || scor !== 16'd0) begin errors++; $display("FAIL pre_cross: got x0=%0d scor=%0d want 420/0", xo(0), scor); end
      do_tick();
      checks++; if (xo(0) != 390) begin errors++; $display("FAIL cross_x0: got %0d want 390", xo(0)); end
      checks++; if (scor !== 16'd1 || scor_puls !== 1'b1) begin errors++; $display("FAIL cross_scor: got %0d/%0b want 1/1", scor, scor_puls); end
      @(negedge clk_148Mhz);
      checks++; if (scor_puls !== 1'b0 || scor !== 16'd1) begin errors++; $display("FAIL puls_width: got %0b/%0d want 0/1", scor_puls, scor); end
      checks++; if (xo(1) != 1050 || xo(2) != 1710) begin errors++; $display("FAIL cross_x12: got %0d,%0d want 1050,1710", xo(1), xo(2)); end
   endtask

   task automatic test_wrap();
      repeat (12) do_tick();
      viteza = 6'd10;
      do_tick();
      checks++; if (xo(0) != 20 || xo(1) != 680 || xo(2) != 1340) begin
         errors++; $display("FAIL pre_wrap: got %0d,%0d,%0d want 20,680,1340", xo(0), xo(1), xo(2)); end
      viteza = 6'd0;
      do_tick();
      checks++; if (xo(0) != 20 || xo(1) != 680) begin errors++; $display("FAIL speed0: got %0d,%0d want 20,680", xo(0), xo(1)); end
      viteza = 6'd30;
      do_tick();
      checks++; if (xo(0) != 1970 || xo(1) != 650 || xo(2) != 1310) begin
         errors++; $display("FAIL wrap_x: got %0d,%0d,%0d want 1970,650,1310", xo(0), xo(1), xo(2)); end
`ifdef OBST_GOL_ALEATOR_EN
      checks++; if (yo(0) < 200 || yo(0) > 711) begin errors++; $display("FAIL wrap_y0: got %0d want 200..711", yo(0)); end
`else
      checks++; if (yo(0) != 456) begin errors++; $display("FAIL wrap_y0: got %0d want 456", yo(0)); end
`endif
      checks++; if (activ !== 3'b110 || scor !== 16'd1) begin errors++; $display("FAIL wrap_activ_scor: got %b/%0d want 110/1", activ, scor); end
   endtask

   task automatic test_pause_stop();
      pauza = 1'b1; tick_obs = 1'b1;
      @(negedge clk_148Mhz);
      tick_obs = 1'b0;
      checks++; if (stare !== 2'd2 || xo(0) != 1970) begin errors++; $display("FAIL pause_enter: got %0d/%0d want 2/1970", stare, xo(0)); end
      repeat (5) do_tick();
      checks++; if (xo(0) != 1970 || xo(1) != 650) begin errors++; $display("FAIL pause_hold: got %0d,%0d want 1970,650", xo(0), xo(1)); end
      pauza = 1'b0;
      @(negedge clk_148Mhz);
      checks++; if (stare !== 2'd1) begin errors++; $display("FAIL pause_exit: got %0d want 1", stare); end
      do_tick();
      checks++; if (xo(0) != 1940) begin errors++; $display("FAIL resume_x0: got %0d want 1940", xo(0)); end
      coliziune = 1'b1; tick_obs = 1'b1;
      @(negedge clk_148Mhz);
      coliziune = 1'b0; tick_obs = 1'b0;
      checks++; if (stare !== 2'd3 || xo(0) != 1940) begin errors++; $display("FAIL stop: got %0d/%0d want 3/1940", stare, xo(0)); end
      repeat (3) do_tick();
      checks++; if (stare !== 2'd3 || xo(0) != 1940 || scor !== 16'd1) begin
         errors++; $display("FAIL stop_frozen: got %0d/%0d/%0d want 3/1940/1", stare, xo(0), scor); end
   endtask

   task automatic test_saturation();
      start = 1'b1;
      @(negedge clk_148Mhz);
      start = 1'b0;
      checks++; if (stare !== 2'd1 || xo(0) != 1920 || scor !== 16'd0) begin
         errors++; $display("FAIL restart: got %0d/%0d/%0d want 1/1920/0", stare, xo(0), scor); end
      viteza = 6'd60;
      force dut.scor_q = 16'hFFFE;
      @(negedge clk_148Mhz);
      release dut.scor_q;
      @(negedge clk_148Mhz);
      checks++; if (scor !== 16'hFFFE) begin errors++; $display("FAIL preload: got %h want fffe", scor); end
      repeat (25) do_tick();
      checks++; if (xo(0) != 420 || scor !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %0d/%h want 420/fffe", xo(0), scor); end
      do_tick();
      checks++; if (xo(0) != 360 || scor !== 16'hFFFF || scor_puls !== 1'b1) begin
         errors++; $display("FAIL sat_first: got %0d/%h/%0b want 360/ffff/1", xo(0), scor, scor_puls); end
      repeat (6) do_tick();
      checks++; if (xo(0) != 0) begin errors++; $display("FAIL x_eq_speed: got %0d want 0", xo(0)); end
      repeat (4) do_tick();
      checks++; if (xo(0) != 1740 || xo(1) != 420) begin errors++; $display("FAIL sat_mid: got %0d,%0d want 1740,420", xo(0), xo(1)); end
      do_tick();
      checks++; if (xo(1) != 360 || xo(0) != 1680) begin errors++; $display("FAIL sat_x: got %0d,%0d want 360,1680", xo(1), xo(0)); end
      checks++; if (scor !== 16'hFFFF || scor_puls !== 1'b1) begin errors++; $display("FAIL sat_hold: got %h/%0b want ffff/1", scor, scor_puls); end
   endtask

   task automatic run_seq(input bit second);
      logic [90:0] rec;
      reset = 1'b1; viteza = 6'd63;
      @(negedge clk_148Mhz);
      checks++; if (stare !== 2'd0 || xo(0) != 1920 || xo(2) != 3240 || yo(1) != 456 || scor !== 16'd0 || scor_puls !== 1'b0) begin
         errors++; $display("FAIL midreset: got stare=%0d x0=%0d x2=%0d y1=%0d scor=%0d", stare, xo(0), xo(2), yo(1), scor); end
      reset = 1'b0; start = 1'b1;
      @(negedge clk_148Mhz);
      start = 1'b0;
      for (int k = 0; k < NLOG; k++) begin
         do_tick();
         rec = {x_obs, y_gol, scor, scor_puls, stare};
         if (second) log_b[k] = rec;
         else        log_a[k] = rec;
      end
   endtask

   task automatic test_reset_replay();
      run_seq(1'b0);
      repeat (7) do_tick();
      run_seq(1'b1);
      for (int k = 0; k < NLOG; k++) begin
         checks++; if (log_b[k] !== log_a[k]) begin errors++; $display("FAIL replay_%0d: got %h want %h", k, log_b[k], log_a[k]); end
      end
      checks++; if (log_a[NLOG-1][2:0] !== 3'b001 || log_a[NLOG-1][18:3] == 16'd0) begin
         errors++; $display("FAIL replay_progress: got stare/puls=%b scor=%0d want 001/nonzero", log_a[NLOG-1][2:0], log_a[NLOG-1][18:3]); end
   endtask

   initial begin
      @(negedge clk_148Mhz);
      test_reset();
      test_motion();
      test_wrap();
      test_pause_stop();
      test_saturation();
      test_reset_replay();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
